// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller state encoding and default LFSR/MISR sizing.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } bist_state_e;

    localparam int unsigned                   BIST_N_PATTERNS = 1000;
    localparam int unsigned                   BIST_SIG_WIDTH  = 16;
    localparam logic [BIST_SIG_WIDTH-1:0]     BIST_GOLDEN_SIG = 16'h0000;

    // Counter must hold N_PATTERNS itself, since it increments on the last RUN cycle.
    function automatic int unsigned bist_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bist_edge_detect.sv
// Registered rising-edge detector for the BIST start request.
module bist_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic edge_o
);

    logic prev_q;
    logic edge_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            prev_q <= level_i;
            edge_q <= level_i & ~prev_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: seeds LFSR, runs N_PATTERNS cycles, flushes MISR, compares signature.
// Optional: define BIST_RESTART_EN to let a start edge restart an in-progress run.
module bist_controller
    import bist_pkg::*;
#(
    parameter int unsigned          N_PATTERNS = BIST_N_PATTERNS,
    parameter int unsigned          SIG_WIDTH  = BIST_SIG_WIDTH,
    parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = SIG_WIDTH'(BIST_GOLDEN_SIG)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 bist_start,
    input  logic [SIG_WIDTH-1:0] misr_signature,
    output logic                 lfsr_seed_load,
    output logic                 lfsr_en,
    output logic                 misr_clear,
    output logic                 misr_en,
    output logic                 test_mode,
    output logic                 bist_end,
    output logic                 pass_nfail
);

    localparam int unsigned     CNT_W    = bist_cnt_width(N_PATTERNS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PATTERNS - 1);

    bist_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_edge;

    logic seed_load_q, seed_load_d;
    logic lfsr_en_q,   lfsr_en_d;
    logic clear_q,     clear_d;
    logic misr_en_q,   misr_en_d;
    logic test_mode_q, test_mode_d;
    logic end_q,       end_d;
    logic pass_q,      pass_d;

    bist_edge_detect u_edge (
        .clk_i   (clock),
        .rst_ni  (reset),
        .level_i (bist_start),
        .edge_o  (start_edge)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) state_d = ST_INIT;
            end
            ST_INIT: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start_edge) state_d = ST_INIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef BIST_RESTART_EN
        if (start_edge && (state_q inside {ST_INIT, ST_RUN, ST_FLUSH, ST_COMPARE})) begin
            state_d = ST_INIT;
        end
`endif

        if (state_d == ST_INIT) cnt_d = '0;
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        seed_load_d = (state_d == ST_INIT);
        clear_d     = (state_d == ST_INIT);
        lfsr_en_d   = (state_d == ST_RUN);
        test_mode_d = (state_d inside {ST_INIT, ST_RUN, ST_FLUSH, ST_COMPARE});
        end_d       = (state_d == ST_DONE);
        misr_en_d   = lfsr_en_q & (state_d != ST_INIT);
        pass_d      = pass_q;
        if (state_d == ST_INIT) begin
            pass_d = 1'b0;
        end else if (state_q == ST_COMPARE) begin
            pass_d = (misr_signature == GOLDEN_SIG);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            seed_load_q <= 1'b0;
            lfsr_en_q   <= 1'b0;
            clear_q     <= 1'b0;
            misr_en_q   <= 1'b0;
            test_mode_q <= 1'b0;
            end_q       <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_load_q <= seed_load_d;
            lfsr_en_q   <= lfsr_en_d;
            clear_q     <= clear_d;
            misr_en_q   <= misr_en_d;
            test_mode_q <= test_mode_d;
            end_q       <= end_d;
            pass_q      <= pass_d;
        end
    end

    assign lfsr_seed_load = seed_load_q;
    assign lfsr_en        = lfsr_en_q;
    assign misr_clear     = clear_q;
    assign misr_en        = misr_en_q;
    assign test_mode      = test_mode_q;
    assign bist_end       = end_q;
    assign pass_nfail     = pass_q;

endmodule

// File: tb/tb_bist_controller.sv
// Scoreboard bench for bist_controller (N_PATTERNS=4 and N_PATTERNS=1 instances).
module tb_bist_controller;

    // Vector order: {seed_load, lfsr_en, misr_clear, misr_en, test_mode, bist_end, pass_nfail}
    localparam logic [6:0] V_IDLE  = 7'b0000000;
    localparam logic [6:0] V_INIT  = 7'b1010100;
    localparam logic [6:0] V_RUN1  = 7'b0100100;
    localparam logic [6:0] V_RUNM  = 7'b0101100;
    localparam logic [6:0] V_FLUSH = 7'b0001100;
    localparam logic [6:0] V_CMP   = 7'b0000100;
    localparam logic [6:0] V_DONEP = 7'b0000011;
    localparam logic [6:0] V_DONEF = 7'b0000010;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] sig = 16'h0000;

    logic o_seed, o_lfsr, o_clr, o_misr, o_tm, o_end, o_pass;
    logic p_seed, p_lfsr, p_clr, p_misr, p_tm, p_end, p_pass;
    logic [6:0] obs, obs1;

    logic [6:0] sb[$];
    logic [6:0] exp_v;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clock = ~clock;

    bist_controller #(.N_PATTERNS(4), .SIG_WIDTH(16), .GOLDEN_SIG(16'hA5C3)) u_dut (
        .clock(clock), .reset(reset), .bist_start(start), .misr_signature(sig),
        .lfsr_seed_load(o_seed), .lfsr_en(o_lfsr), .misr_clear(o_clr), .misr_en(o_misr),
        .test_mode(o_tm), .bist_end(o_end), .pass_nfail(o_pass)
    );

    bist_controller #(.N_PATTERNS(1), .SIG_WIDTH(16), .GOLDEN_SIG(16'hA5C3)) u_dut1 (
        .clock(clock), .reset(reset), .bist_start(start1), .misr_signature(sig),
        .lfsr_seed_load(p_seed), .lfsr_en(p_lfsr), .misr_clear(p_clr), .misr_en(p_misr),
        .test_mode(p_tm), .bist_end(p_end), .pass_nfail(p_pass)
    );

    assign obs  = {o_seed, o_lfsr, o_clr, o_misr, o_tm, o_end, o_pass};
    assign obs1 = {p_seed, p_lfsr, p_clr, p_misr, p_tm, p_end, p_pass};

    // Expected per-cycle vectors of one run; entry 0 is the cycle the edge is first sampled.
    task automatic push_run(input int unsigned n, input logic pass, input logic [6:0] prev,
                            input int unsigned hold);
        sb.push_back(prev);
        sb.push_back(V_INIT);
        for (int unsigned i = 0; i < n; i++) sb.push_back((i == 0) ? V_RUN1 : V_RUNM);
        sb.push_back(V_FLUSH);
        sb.push_back(V_CMP);
        for (int unsigned i = 0; i < hold; i++) sb.push_back({5'b00000, 1'b1, pass});
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        sig   = 16'hA5C3;
        repeat (3) sb.push_back(V_IDLE);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_hold: got %b expected %b", obs, exp_v);
            end
        end
        reset = 1'b1;
        repeat (2) sb.push_back(V_IDLE);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_idle: got %b expected %b", obs, exp_v);
            end
        end
    endtask

    task automatic test_pass;
        sig   = 16'hA5C3;
        start = 1'b1;
        push_run(4, 1'b1, V_IDLE, 3);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL nominal_pass: got %b expected %b", obs, exp_v);
            end
        end
        start = 1'b0;
        repeat (2) sb.push_back(V_DONEP);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL pass_hold: got %b expected %b", obs, exp_v);
            end
        end
    endtask

    task automatic test_fail;
        sig   = 16'hA5C2;
        start = 1'b1;
        push_run(4, 1'b0, V_DONEP, 3);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL sig_mismatch: got %b expected %b", obs, exp_v);
            end
        end
        start = 1'b0;
        repeat (2) sb.push_back(V_DONEF);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL fail_hold: got %b expected %b", obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back;
        sig   = 16'hA5C3;
        start = 1'b1;
        push_run(4, 1'b1, V_DONEF, 42);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL held_start: got %b expected %b", obs, exp_v);
            end
        end
        start = 1'b0;
        repeat (2) sb.push_back(V_DONEP);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL held_release: got %b expected %b", obs, exp_v);
            end
        end
        start = 1'b1;
        push_run(4, 1'b1, V_DONEP, 2);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL second_run: got %b expected %b", obs, exp_v);
            end
        end
        start = 1'b0;
        repeat (2) sb.push_back(V_DONEP);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL second_hold: got %b expected %b", obs, exp_v);
            end
        end
    endtask

    task automatic test_restart;
        sig   = 16'hA5C2;
        start = 1'b1;
        push_run(4, 1'b0, V_DONEP, 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL restart_pre: got %b expected %b", obs, exp_v);
            end
        end
        start = 1'b0;
        @(negedge clock);
        exp_v = sb.pop_front();
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL restart_drop: got %b expected %b", obs, exp_v);
        end
        start = 1'b1;
`ifdef BIST_RESTART_EN
        sb.delete();
        push_run(4, 1'b0, V_RUNM, 2);
`endif
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL edge_in_run: got %b expected %b", obs, exp_v);
            end
        end
        start = 1'b0;
        sb.push_back(V_DONEF);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL restart_hold: got %b expected %b", obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        sig   = 16'hA5C3;
        start = 1'b1;
        push_run(4, 1'b1, V_DONEF, 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL abort_pre: got %b expected %b", obs, exp_v);
            end
        end
        sb.delete();
        reset = 1'b0;
        sb.push_back(V_IDLE);
        #1;
        exp_v = sb.pop_front();
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL async_reset: got %b expected %b", obs, exp_v);
        end
        repeat (2) sb.push_back(V_IDLE);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL abort_idle: got %b expected %b", obs, exp_v);
            end
        end
        reset = 1'b1;
        push_run(4, 1'b1, V_IDLE, 2);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL start_after_reset: got %b expected %b", obs, exp_v);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_single_pattern;
        sig    = 16'hA5C3;
        start1 = 1'b1;
        push_run(1, 1'b1, V_IDLE, 2);
        while (sb.size() != 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            vectors++;
            if (obs1 !== exp_v) begin
                miscompares++;
                $display("FAIL n_patterns_1: got %b expected %b", obs1, exp_v);
            end
        end
        start1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_back_to_back();
        test_restart();
        test_reset_mid_run();
        test_single_pattern();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
